// File: rtl/sequence_detector.sv
// Run-length detector: z=1 while the last LEN samples of w are all equal.
// Moore output decoded from registered state, 1-cycle latency; no backpressure, w sampled every edge.
module sequence_detector #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic z
);

  localparam int              CW      = $clog2(LEN + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(LEN);

  logic [LEN-1:0] r_sr;
  logic [CW-1:0]  r_cnt;
  logic           w_full;
  logic           w_uniform;

  // The fill counter keeps the all-zero reset contents of r_sr from looking like a real run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr <= {r_sr[LEN-2:0], w};
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_full    = (r_cnt == CNT_MAX);
  assign w_uniform = (&r_sr) | ~(|r_sr);
  assign z         = w_full & w_uniform;

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector with LEN=4; z sampled 1 time unit after each rising edge.
module tb_sequence_detector;

  logic clk;
  logic reset;
  logic w;
  logic z;

  int checks;
  int errors;

  sequence_detector #(.LEN(4)) dut (
    .clk  (clk),
    .reset(reset),
    .w    (w),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    errors = errors + 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drive one sample and advance to just after the edge that captures it.
  task automatic push(input logic b);
    w = b;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    w = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks = checks + 1;
      if (z !== 1'b0) begin
        $display("FAIL reset_hold[%0d]: z=%b required=0", i, z);
        errors = errors + 1;
      end
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1'b0);
      checks = checks + 1;
      if (z !== (i == 3)) begin
        $display("FAIL reset_zeros[%0d]: z=%b required=%b", i, z, (i == 3));
        errors = errors + 1;
      end
    end
  endtask

  task automatic test_startup_guard();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push(1'b0);
      checks = checks + 1;
      if (z !== 1'b0) begin
        $display("FAIL startup_guard[%0d]: z=%b required=0", i, z);
        errors = errors + 1;
      end
    end
  endtask

  task automatic test_interrupted();
    logic [5:0] stim;
    stim = 6'b110001;
    apply_reset();
    for (int i = 5; i >= 0; i--) begin
      push(stim[i]);
      checks = checks + 1;
      if (z !== 1'b0) begin
        $display("FAIL interrupted[%0d]: z=%b required=0", 5 - i, z);
        errors = errors + 1;
      end
    end
  endtask

  task automatic test_ones_overlap();
    logic [6:0] stim;
    logic [6:0] expz;
    stim = 7'b1111110;
    expz = 7'b0001110;
    apply_reset();
    for (int i = 6; i >= 0; i--) begin
      push(stim[i]);
      checks = checks + 1;
      if (z !== expz[i]) begin
        $display("FAIL ones_overlap[%0d]: z=%b required=%b", 6 - i, z, expz[i]);
        errors = errors + 1;
      end
    end
  endtask

  task automatic test_polarity_switch();
    logic [7:0] stim;
    logic [7:0] expz;
    stim = 8'b11110000;
    expz = 8'b00010001;
    apply_reset();
    for (int i = 7; i >= 0; i--) begin
      push(stim[i]);
      checks = checks + 1;
      if (z !== expz[i]) begin
        $display("FAIL polarity_switch[%0d]: z=%b required=%b", 7 - i, z, expz[i]);
        errors = errors + 1;
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) push(1'b1);
    checks = checks + 1;
    if (z !== 1'b1) begin
      $display("FAIL async_pre: z=%b required=1", z);
      errors = errors + 1;
    end
    #2;
    reset = 1'b0;
    #1;
    checks = checks + 1;
    if (z !== 1'b0) begin
      $display("FAIL async_drop: z=%b required=0", z);
      errors = errors + 1;
    end
    @(posedge clk);
    #1;
    checks = checks + 1;
    if (z !== 1'b0) begin
      $display("FAIL async_hold: z=%b required=0", z);
      errors = errors + 1;
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1'b1);
      checks = checks + 1;
      if (z !== (i == 3)) begin
        $display("FAIL async_restart[%0d]: z=%b required=%b", i, z, (i == 3));
        errors = errors + 1;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w      = 1'b0;
    reset  = 1'b0;
    #3;
    test_reset();
    test_startup_guard();
    test_interrupted();
    test_ones_overlap();
    test_polarity_switch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
